// File: rtl/pagerank_update.sv
// PageRank damping stage: PR_new = base_term + floor(d*sum), serial 16-cycle shift-add multiply.
// Optional convergence tracking (running max |delta|, max_delta, converged) under `PR_CONV_TRACK_EN.
module pagerank_update #(
    parameter int VID_W = 16,
    parameter int DAMP  = 55706,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VID_W-1:0] in_vertex,
    input  logic [31:0]      in_sum,
    input  logic [31:0]      in_old_pr,
    input  logic             in_last,
    input  logic [31:0]      base_term,
    input  logic [31:0]      threshold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VID_W-1:0] out_vertex,
    output logic [31:0]      out_pr,
    output logic             sweep_done,
    output logic [31:0]      max_delta,
    output logic             converged
);

    localparam logic [15:0] DAMP_BITS = DAMP[15:0];

    typedef enum logic [1:0] {IDLE, MUL, ADD, OUT} state_t;

    state_t             r_state;
    state_t             w_next;

    logic [VID_W-1:0]   r_vertex;
    logic [31:0]        r_sum;
    logic               r_last;
    logic [47:0]        r_acc;
    logic [3:0]         r_cnt;
    logic [VID_W-1:0]   r_out_vertex;
    logic [31:0]        r_out_pr;
    logic               r_sweep_done;

    logic [31:0]        w_prod;
    logic [32:0]        w_pr_wide;
    logic [31:0]        w_pr;

    // Product is the integer part of the Q16.16 x Q0.16 result; d<1 keeps it within 32 bits.
    assign w_prod    = r_acc[FRAC +: 32];
    assign w_pr_wide = {1'b0, base_term} + {1'b0, w_prod};
    assign w_pr      = w_pr_wide[32] ? '1 : w_pr_wide[31:0];

`ifdef PR_CONV_TRACK_EN
    logic [31:0]        r_old_pr;
    logic [31:0]        r_run_max;
    logic [31:0]        r_max_delta;
    logic               r_converged;
    logic [31:0]        w_delta;

    assign w_delta = (w_pr >= r_old_pr) ? (w_pr - r_old_pr) : (r_old_pr - w_pr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_old_pr    <= '0;
            r_run_max   <= '0;
            r_max_delta <= '0;
            r_converged <= 1'b0;
        end else begin
            if (r_state == IDLE && in_valid)
                r_old_pr <= in_old_pr;
            if (r_state == ADD && w_delta > r_run_max)
                r_run_max <= w_delta;
            // Running max already holds the current vertex's delta from the ADD cycle.
            if (r_state == OUT && out_ready && r_last) begin
                r_max_delta <= r_run_max;
                r_converged <= (r_run_max <= threshold);
                r_run_max   <= '0;
            end
        end
    end

    assign max_delta = r_max_delta;
    assign converged = r_converged;
`else
    logic w_unused;
    assign w_unused  = ^{threshold, in_old_pr};
    assign max_delta = '0;
    assign converged = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)        w_next = MUL;
            MUL:     if (r_cnt == 4'd15)  w_next = ADD;
            ADD:                          w_next = OUT;
            OUT:     if (out_ready)       w_next = IDLE;
            default:                      w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == OUT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vertex     <= '0;
            r_sum        <= '0;
            r_last       <= 1'b0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_out_vertex <= '0;
            r_out_pr     <= '0;
            r_sweep_done <= 1'b0;
        end else begin
            r_sweep_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_vertex <= in_vertex;
                        r_sum    <= in_sum;
                        r_last   <= in_last;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                MUL: begin
                    if (DAMP_BITS[r_cnt])
                        r_acc <= r_acc + ({16'b0, r_sum} << r_cnt);
                    r_cnt <= r_cnt + 4'd1;
                end
                ADD: begin
                    r_out_pr     <= w_pr;
                    r_out_vertex <= r_vertex;
                end
                OUT: begin
                    if (out_ready && r_last)
                        r_sweep_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_vertex = r_out_vertex;
    assign out_pr     = r_out_pr;
    assign sweep_done = r_sweep_done;

endmodule

// File: tb/tb_pagerank_update.sv
// Scoreboard bench for pagerank_update: directed test-plan cases plus randomized vertices.
module tb_pagerank_update;

    localparam int VID_W = 16;
    localparam int DAMP  = 55706;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [VID_W-1:0] in_vertex = '0;
    logic [31:0]      in_sum = '0;
    logic [31:0]      in_old_pr = '0;
    logic             in_last = 1'b0;
    logic [31:0]      base_term = '0;
    logic [31:0]      threshold = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [VID_W-1:0] out_vertex;
    logic [31:0]      out_pr;
    logic             sweep_done;
    logic [31:0]      max_delta;
    logic             converged;

    pagerank_update #(.VID_W(VID_W), .DAMP(DAMP), .FRAC(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_vertex(in_vertex),
        .in_sum(in_sum), .in_old_pr(in_old_pr), .in_last(in_last),
        .base_term(base_term), .threshold(threshold),
        .out_valid(out_valid), .out_ready(out_ready), .out_vertex(out_vertex),
        .out_pr(out_pr), .sweep_done(sweep_done), .max_delta(max_delta),
        .converged(converged)
    );

    always #5 clk = ~clk;

    typedef struct { logic [VID_W-1:0] v; logic [31:0] pr; } res_t;
    typedef struct { logic [31:0] md; logic cv; } sweep_t;

    res_t        exp_q[$];
    sweep_t      sweep_q[$];
    logic [31:0] run_max = '0;
    int unsigned errors = 0;
    int unsigned checks = 0;
    bit          rand_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_pr(input logic [31:0] b, input logic [31:0] s);
        longint unsigned p;
        longint unsigned t;
        p = (64'(DAMP) * 64'(s)) >> 16;
        t = p + 64'(b);
        return (t > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
    endfunction

    // Issue one vertex; the reference result and any sweep summary are queued at accept.
    task automatic send(input logic [VID_W-1:0] v, input logic [31:0] s,
                        input logic [31:0] o, input logic last);
        int unsigned n = 0;
        logic [31:0] pr;
        logic [31:0] d;
        sweep_t sw;
        in_valid = 1'b1; in_vertex = v; in_sum = s; in_old_pr = o; in_last = last;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!in_ready) chk("accept_timeout", 0, 1);
        pr = model_pr(base_term, s);
        d  = (pr >= o) ? pr - o : o - pr;
        if (d > run_max) run_max = d;
        exp_q.push_back('{v: v, pr: pr});
        if (last) begin
`ifdef PR_CONV_TRACK_EN
            sw.md = run_max;
            sw.cv = (run_max <= threshold);
`else
            sw.md = '0;
            sw.cv = 1'b0;
`endif
            sweep_q.push_back(sw);
            run_max = '0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (!(in_ready && exp_q.size() == 0) && n < 400) begin @(posedge clk); #1; n++; end
        chk("idle_reached", {63'b0, in_ready}, 64'd1);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("out_vertex", 64'(out_vertex), 64'(e.v));
                    chk("out_pr", 64'(out_pr), 64'(e.pr));
                end
            end
            if (sweep_done) begin
                if (sweep_q.size() == 0) chk("unexpected_sweep_done", 1, 0);
                else begin
                    sweep_t s;
                    s = sweep_q.pop_front();
                    chk("max_delta", 64'(max_delta), 64'(s.md));
                    chk("converged", 64'(converged), 64'(s.cv));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #2;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        logic [31:0] pr0;
        logic [31:0] bp_pr;
        int unsigned seen;

        #1;
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_pr", 64'(out_pr), 64'd0);
        chk("rst_max_delta", 64'(max_delta), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Nominal vertex, latency measurement, converged with threshold 0x2000.
        base_term = 32'h0000_1000; threshold = 32'h0000_2000; out_ready = 1'b1;
        send(16'h0007, 32'h0001_0000, 32'h0001_0000, 1'b1);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin k = i; break; end
        end
        chk("latency", 64'(k), 64'd17);
        chk("nominal_pr", 64'(out_pr), 64'h0000_E99A);
        wait_idle();
        threshold = 32'h0000_1000;
        send(16'h0008, 32'h0001_0000, 32'h0001_0000, 1'b1);
        wait_idle();

        // Saturation.
        base_term = 32'hFFFF_FFFF;
        send(16'h0009, 32'hFFFF_FFFF, 32'h0, 1'b0);
        wait_idle();

        // Backpressure: out_ready low for five observed cycles, handshake on the sixth.
        base_term = 32'h0000_1000;
        out_ready = 1'b0;
        bp_pr = model_pr(base_term, 32'h0002_3456);
        send(16'h00AB, 32'h0002_3456, 32'h0, 1'b1);
        k = 0;
        while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
            chk("bp_out_pr", 64'(out_pr), 64'(bp_pr));
            chk("bp_out_vertex", 64'(out_vertex), 64'h00AB);
            chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_after_out_valid", {63'b0, out_valid}, 64'd0);
        chk("bp_after_in_ready", {63'b0, in_ready}, 64'd1);
        wait_idle();

        // Multi-vertex sweeps; running max must restart between sweeps.
        threshold = 32'h0000_0100;
        pr0 = model_pr(base_term, 32'h0001_0000);
        send(16'd1, 32'h0001_0000, pr0 - 32'h10, 1'b0);
        send(16'd2, 32'h0001_0000, pr0 + 32'h200, 1'b0);
        send(16'd3, 32'h0001_0000, pr0 - 32'h5, 1'b1);
        wait_idle();
        send(16'd4, 32'h0001_0000, pr0 + 32'h20, 1'b0);
        send(16'd5, 32'h0001_0000, pr0 - 32'h80, 1'b1);
        wait_idle();

        // Randomized vertices with random downstream stalls.
        rand_ready = 1'b1;
        for (int sw = 0; sw < 4; sw++) begin
            base_term = $urandom_range(0, 32'h0002_0000);
            threshold = $urandom_range(0, 32'h0001_0000);
            for (int v = 0; v < 6; v++)
                send(16'($urandom), $urandom_range(0, 32'h0004_0000),
                     $urandom_range(0, 32'h0004_0000), (v == 5) || ($urandom_range(0, 4) == 0));
            wait_idle();
        end
        @(posedge clk); #1;
        rand_ready = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Reset eight cycles into MUL discards the vertex.
        send(16'h0055, 32'h0001_0000, 32'h0, 1'b1);
        repeat (8) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete(); sweep_q.delete(); run_max = '0;
        #1;
        chk("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("mid_rst_out_pr", 64'(out_pr), 64'd0);
        chk("mid_rst_out_vertex", 64'(out_vertex), 64'd0);
        chk("mid_rst_sweep_done", {63'b0, sweep_done}, 64'd0);
        chk("mid_rst_max_delta", 64'(max_delta), 64'd0);
        chk("mid_rst_converged", {63'b0, converged}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
        seen = 0;
        repeat (25) begin @(posedge clk); #1; if (out_valid) seen++; end
        chk("post_rst_no_out_valid", 64'(seen), 64'd0);
        base_term = 32'h0000_1000; threshold = 32'h0000_2000;
        send(16'h0066, 32'h0001_0000, 32'h0001_0000, 1'b1);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("results_drained", 64'(exp_q.size()), 64'd0);
        chk("sweeps_drained", 64'(sweep_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pagerank_update.md
Name: pagerank_update

Overview:
- Downstream consumer of the per-vertex reduction stage.
- Takes each vertex's completed contribution sum, sum = Σ PR(u)/outdeg(u), and applies damping: PR_new = base + d·sum.
- Tracks the largest |PR_new − PR_old| across a sweep and flags convergence at sweep end.
- Results go to the rank write-back path through a valid/ready handshake.

Parameters:
- VID_W, 16, vertex index width.
- DAMP, 55706, damping factor d as a 16-bit unsigned fraction (d = DAMP/65536; 55706 ≈ 0.85); must be < 65536.
- FRAC, 16, fractional bits of all rank/sum values (unsigned Q16.16, 32-bit).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream result valid
- in_ready  out  1  block can accept
- in_vertex  in  VID_W  vertex index
- in_sum  in  32  reduced sum, Q16.16
- in_old_pr  in  32  previous rank of vertex, Q16.16
- in_last  in  1  final vertex of current sweep
- base_term  in  32  (1−d)/N, Q16.16; static during a sweep
- threshold  in  32  convergence threshold, Q16.16; static during a sweep
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_vertex  out  VID_W  vertex index of result
- out_pr  out  32  new rank, Q16.16
- sweep_done  out  1  one-cycle pulse at end of sweep
- max_delta  out  32  max |delta| of last completed sweep
- converged  out  1  max_delta <= threshold, last completed sweep

Behaviour:
- Reset (async, reset=0):
  - Outputs: in_ready=1, out_valid=0, out_vertex=0, out_pr=0, sweep_done=0, max_delta=0, converged=0.
  - Internal: running max cleared, state=IDLE.
  - Any in-flight vertex is discarded, including one in the middle of MUL.
- States: IDLE, MUL, ADD, OUT.
- IDLE:
  - in_ready=1.
  - On the in_valid & in_ready edge (T0): capture vertex, sum, old_pr, last; clear the 48-bit accumulator and the 4-bit cnt; go to MUL.
- MUL (sequential shift-add, one multiplier bit per cycle):
  - Edges T1..T16: if DAMP[cnt]=1 then acc += {16'b0, sum} << cnt; cnt++.
  - The edge where cnt==15 goes to ADD.
- ADD (edge T17):
  - prod = acc[47:16], i.e. floor(d·sum). This never overflows because d<1.
  - pr = base_term + prod, computed 33-bit; saturate to 32'hFFFFFFFF on carry.
  - delta = |pr − old_pr|.
  - `PR_CONV_TRACK_EN` only: running_max = max(running_max, delta).
  - Register out_pr and out_vertex; set out_valid=1; go to OUT.
- Latency: out_valid is high 17 cycles after the accepting edge.
- Throughput: at most one vertex per 19 cycles with out_ready held high.
- OUT:
  - out_valid=1 and in_ready=0.
  - out_pr and out_vertex stay stable until the out_valid & out_ready edge, which clears out_valid and returns to IDLE.
  - If the captured last=1 at that edge:
    - Pulse sweep_done high for exactly one cycle.
    - Load max_delta from running_max, including the current vertex.
    - converged <= (running_max <= threshold).
    - Clear running_max to 0.
- max_delta and converged hold their values until the next sweep end or reset.
- Backpressure: no new input is accepted while in MUL, ADD or OUT; in_ready=0 in all three.
- Single-vertex sweep (in_last on the first vertex) is valid: max_delta equals that vertex's delta.
- in_valid has no effect outside IDLE; the upstream must hold the data until in_ready.

Optional Feature:
- Macro `PR_CONV_TRACK_EN`.
- Defined: delta computation, running max, max_delta and converged behave as above.
- Undefined:
  - Delta and running-max logic are removed.
  - max_delta is tied to 0 and converged to 0.
  - sweep_done still pulses on the last-vertex handshake.
  - Datapath and latency are unchanged.

Test Plan:
- Nominal: DAMP=55706, base_term=0x00001000, in_sum=0x00010000, in_old_pr=0x00010000, in_last=1, out_ready=1.
  - out_pr=0x0000E99A, out_valid 17 cycles after accept.
  - sweep_done pulse, max_delta=0x00001666, converged=1 if threshold=0x2000, 0 if threshold=0x1000.
- Saturation: in_sum=0xFFFFFFFF, base_term=0xFFFFFFFF -> out_pr=0xFFFFFFFF.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises.
  - out_valid, out_pr and out_vertex are stable; in_ready=0.
  - Handshake on cycle 6, then in_ready=1 on the next cycle.
- Multi-vertex sweep: three vertices with deltas 0x10, 0x200, 0x5, last on the third, threshold=0x100.
  - One sweep_done pulse, max_delta=0x200, converged=0.
  - Next sweep with deltas 0x20, 0x80 -> max_delta=0x80, converged=1; running max is reset between sweeps.
- Reset mid-op: assert reset 8 cycles into MUL.
  - All outputs go to reset values immediately; no out_valid follows.
  - in_ready=1 after release, and the next vertex processes normally.
- Build without `PR_CONV_TRACK_EN`: repeat the nominal test.
  - out_pr=0x0000E99A and sweep_done pulses.
  - max_delta=0 and converged=0.
